// File: rtl/apb_master_if.sv
// Command-port and APB-side signal bundle for apb_master.
// The master modport is the requester's view; slave is the peer (bus + command source).
interface apb_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [AW-1:0]         cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [SW-1:0]         cmd_strb_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_slverr_o;
    logic [AW-1:0]         PADDR_o;
    logic                  PWRITE_o;
    logic [DATA_WIDTH-1:0] PWDATA_o;
    logic [SW-1:0]         PSTRB_o;
    logic                  PSEL_o;
    logic                  PENABLE_o;
    logic [DATA_WIDTH-1:0] PRDATA_i;
    logic                  PREADY_i;
    logic                  PSLVERR_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  PRDATA_i, PREADY_i, PSLVERR_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
        output PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output PRDATA_i, PREADY_i, PSLVERR_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
        input  PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o
    );
endinterface

// File: rtl/apb_master.sv
// APB4 requester: single-beat valid/ready commands -> SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic         PCLK_i,
    input logic         PRESETn_i,
    apb_master_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t state, state_d;

    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;

    logic accept;
    logic done;
    logic timeout;

    assign accept = (state == IDLE) && bus.cmd_valid_i && ready_q;
    assign done   = (state == ACCESS) && bus.PREADY_i;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // PREADY in the limit cycle wins: that is a normal completion
    assign timeout = (state == ACCESS) && !bus.PREADY_i
                   && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i)
            wait_cnt <= '0;
        else if (state == SETUP)
            wait_cnt <= '0;
        else if (state == ACCESS && !bus.PREADY_i)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state       <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            slverr_q    <= slverr_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (done || timeout) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        slverr_d    = slverr_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        case (state)
            IDLE: begin
                ready_d   = 1'b1;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (accept) begin
                    ready_d = 1'b0;
                    psel_d  = 1'b1;
                    addr_d  = bus.cmd_addr_i;
                    write_d = bus.cmd_write_i;
                    wdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                    strb_d  = bus.cmd_write_i ? bus.cmd_strb_i : '0;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done || timeout) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    slverr_d    = done ? bus.PSLVERR_i : 1'b1;
                    rdata_d     = (done && !write_q) ? bus.PRDATA_i : '0;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

    assign bus.cmd_ready_o  = ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_slverr_o = slverr_q;
    assign bus.PADDR_o      = addr_q;
    assign bus.PWRITE_o     = write_q;
    assign bus.PWDATA_o     = wdata_q;
    assign bus.PSTRB_o      = strb_q;
    assign bus.PSEL_o       = psel_q;
    assign bus.PENABLE_o    = penable_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write/read, wait states, slave error,
// back-to-back commands, reset mid-transfer and the optional timeout.
module tb_apb_master;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   en_cnt;
    logic got_rsp;

    apb_master_if #(.DATA_WIDTH(32), .DEPTH(1024)) bus ();

    apb_master #(
        .DATA_WIDTH(32),
        .DEPTH(1024),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK_i(clk),
        .PRESETn_i(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and return ticks from accept to response (-1 = none).
    task automatic run_cmd(input logic w, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int budget, output int n);
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        bus.cmd_strb_i  = s;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.rsp_valid_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.PRDATA_i    = '0;
        bus.PREADY_i    = 1'b0;
        bus.PSLVERR_i   = 1'b0;
        tick();
        tick();
        check("rst_ready", bus.cmd_ready_o, 0);
        check("rst_psel", bus.PSEL_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", bus.cmd_ready_o, 1);

        // write, zero wait
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 10'h010;
        bus.cmd_wdata_i = 32'hDEADBEEF;
        bus.cmd_strb_i  = 4'hF;
        bus.PREADY_i    = 1'b1;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        check("t1_setup_psel", bus.PSEL_o, 1);
        check("t1_setup_pen", bus.PENABLE_o, 0);
        check("t1_paddr", bus.PADDR_o, 64'h010);
        check("t1_pwrite", bus.PWRITE_o, 1);
        check("t1_pwdata", bus.PWDATA_o, 64'hDEADBEEF);
        check("t1_pstrb", bus.PSTRB_o, 64'hF);
        check("t1_ready_low", bus.cmd_ready_o, 0);
        tick();
        check("t1_access_pen", bus.PENABLE_o, 1);
        check("t1_access_psel", bus.PSEL_o, 1);
        tick();
        check("t1_rsp_valid", bus.rsp_valid_o, 1);
        check("t1_slverr", bus.rsp_slverr_o, 0);
        check("t1_rdata", bus.rsp_rdata_o, 0);
        check("t1_ready_back", bus.cmd_ready_o, 1);
        check("t1_psel_off", bus.PSEL_o, 0);
        tick();
        check("t1_rsp_one_cycle", bus.rsp_valid_o, 0);

        // read with 2 wait states
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 10'h3FF;
        bus.cmd_wdata_i = 32'h55555555;
        bus.cmd_strb_i  = 4'hF;
        bus.PREADY_i    = 1'b0;
        bus.PRDATA_i    = 32'hBAD0BAD0;
        bus.PSLVERR_i   = 1'b1;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        check("t2_paddr", bus.PADDR_o, 64'h3FF);
        check("t2_pwrite", bus.PWRITE_o, 0);
        check("t2_pstrb", bus.PSTRB_o, 0);
        check("t2_pwdata", bus.PWDATA_o, 0);
        en_cnt  = 0;
        got_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid_o) begin
                got_rsp = 1'b1;
                break;
            end
            if (bus.PENABLE_o) en_cnt++;
            if (en_cnt == 3) begin
                bus.PREADY_i  = 1'b1;
                bus.PRDATA_i  = 32'h12345678;
                bus.PSLVERR_i = 1'b0;
            end
        end
        check("t2_got_rsp", got_rsp, 1);
        check("t2_penable_cycles", en_cnt, 3);
        check("t2_rdata", bus.rsp_rdata_o, 64'h12345678);
        check("t2_slverr", bus.rsp_slverr_o, 0);

        // slave error, then clean write clears it
        bus.PRDATA_i  = 32'hCAFEF00D;
        bus.PSLVERR_i = 1'b1;
        run_cmd(1'b0, 10'h005, 32'h0, 4'hF, 20, cyc);
        check("t3_latency", cyc, 2);
        check("t3_slverr", bus.rsp_slverr_o, 1);
        check("t3_rdata", bus.rsp_rdata_o, 64'hCAFEF00D);
        bus.PSLVERR_i = 1'b0;
        bus.PRDATA_i  = 32'h0;
        tick();
        check("t3_hold_slverr", bus.rsp_slverr_o, 1);
        check("t3_hold_rdata", bus.rsp_rdata_o, 64'hCAFEF00D);
        run_cmd(1'b1, 10'h006, 32'h0000_00AA, 4'h1, 20, cyc);
        check("t3_next_latency", cyc, 2);
        check("t3_next_slverr", bus.rsp_slverr_o, 0);
        check("t3_next_rdata", bus.rsp_rdata_o, 0);

        // back-to-back, cmd_valid held high
        bus.PREADY_i    = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.cmd_addr_i = 10'(10'h100 + k);
            bus.PRDATA_i   = 32'hA0A00000 + k;
            tick();
            check("t4_setup", {bus.PSEL_o, bus.PENABLE_o}, 2'b10);
            check("t4_paddr", bus.PADDR_o, 64'(10'h100 + k));
            tick();
            check("t4_access", {bus.PSEL_o, bus.PENABLE_o}, 2'b11);
            tick();
            check("t4_rsp_valid", bus.rsp_valid_o, 1);
            check("t4_rdata", bus.rsp_rdata_o, 64'(32'hA0A00000 + k));
            check("t4_ready", bus.cmd_ready_o, 1);
        end
        bus.cmd_valid_i = 1'b0;
        tick();
        check("t4_idle", bus.PSEL_o, 0);

        // reset during first wait cycle
        bus.PREADY_i    = 1'b0;
        bus.cmd_addr_i  = 10'h007;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        tick();
        check("t5_in_access", bus.PENABLE_o, 1);
        rst_n = 1'b0;
        #1;
        check("t5_psel_async", bus.PSEL_o, 0);
        check("t5_pen_async", bus.PENABLE_o, 0);
        bus.PREADY_i = 1'b1;
        tick();
        check("t5_no_rsp", bus.rsp_valid_o, 0);
        rst_n = 1'b1;
        tick();
        check("t5_ready", bus.cmd_ready_o, 1);
        check("t5_no_rsp_after", bus.rsp_valid_o, 0);
        check("t5_psel_idle", bus.PSEL_o, 0);

        // PREADY stuck low
        bus.PREADY_i = 1'b0;
        bus.PRDATA_i = 32'hFFFFFFFF;
`ifdef APB_MASTER_TIMEOUT_EN
        run_cmd(1'b0, 10'h009, 32'h0, 4'h0, 20, cyc);
        check("t6_timeout_latency", cyc, 5);
        check("t6_timeout_slverr", bus.rsp_slverr_o, 1);
        check("t6_timeout_rdata", bus.rsp_rdata_o, 0);
        check("t6_timeout_psel", bus.PSEL_o, 0);
`else
        run_cmd(1'b0, 10'h009, 32'h0, 4'h0, 100, cyc);
        check("t6_no_rsp_100", cyc, 64'hFFFFFFFF_FFFFFFFF);
        check("t6_still_access", {bus.PSEL_o, bus.PENABLE_o}, 2'b11);
        bus.PREADY_i = 1'b1;
        tick();
        check("t6_late_rsp", bus.rsp_valid_o, 1);
        check("t6_late_rdata", bus.rsp_rdata_o, 64'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
